// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared channel state type and reset divisor for the multi-channel clock divider.
// Contents: ch_state_e (IDLE/RUN/DRAIN) and DEF_DIV, the half-period each channel holds out of reset.
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_e;
    localparam int DEF_DIV = 100;
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control and divided-clock bundle between the slow-time consumers and the divider.
// Signals: en (per-channel run request), div_i (packed half-periods), sync_i (phase-align pulse),
//          clk_o/tick_o/busy_o (per-channel divided clock, rise strobe, activity flag).
// Modports: master drives the controls, slave is the divider.
interface clk_div_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] div_i;
    logic                  sync_i;
    logic [N_CH-1:0]       clk_o;
    logic [N_CH-1:0]       tick_o;
    logic [N_CH-1:0]       busy_o;
    modport master (output en, div_i, sync_i, input clk_o, tick_o, busy_o);
    modport slave  (input en, div_i, sync_i, output clk_o, tick_o, busy_o);
endinterface

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel producing a 50% duty clock of period 2*D and a rise strobe.
// Ports: clk, rst_n (async active-low); en_i run request; div_i half-period (0 acts as 1);
//        sync_i phase restart; clk_o divided clock; tick_o strobe on each rise; busy_o not idle.
module clk_div_ch #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             sync_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o
);
    import clk_div_pkg::*;

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, d_q, d_d, d_eff;
    logic             clk_q, clk_d, tick_q, tick_d, tc, run_on;

    assign d_eff  = (div_i == '0) ? CNT_W'(1) : div_i;
    assign tc     = cnt_q == d_q - CNT_W'(1);
    assign run_on = (state_q == RUN) && en_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        d_d     = d_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (en_i) begin
                d_d     = d_eff;
                state_d = RUN;
            end
        end else if (sync_i) begin
            // sync wins over a coincident terminal count: no toggle, no tick
            cnt_d   = '0;
            clk_d   = 1'b0;
            d_d     = d_eff;
            state_d = run_on ? RUN : IDLE;
        end else if (tc) begin
            // half-period boundary: the only place a new divisor is taken
            cnt_d   = '0;
            clk_d   = run_on ? !clk_q : 1'b0;
            tick_d  = run_on && !clk_q;
            d_d     = run_on ? d_eff : d_q;
            state_d = run_on ? RUN : IDLE;
        end else if (state_q == RUN && !en_i) begin
            // a low phase may stop at once; a high phase must run to completion
            cnt_d   = clk_q ? cnt_q + CNT_W'(1) : '0;
            state_d = clk_q ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= CNT_W'(DEF_DIV);
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign busy_o = state_q != IDLE;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock-divider channels sharing one clock and a common sync pulse.
// Ports: clk, rst_n (async active-low); bus (slave side of clk_div_multi_if) carrying
//        en/div_i/sync_i in and clk_o/tick_o/busy_o out; channel k uses div_i[k*CNT_W +: CNT_W].
module clk_div_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input logic              clk,
    input logic              rst_n,
    clk_div_multi_if.slave   bus
);
    logic [N_CH-1:0] clk_v, tick_v, busy_v;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        clk_div_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (bus.en[k]),
            .div_i  (bus.div_i[k*CNT_W +: CNT_W]),
            .sync_i (bus.sync_i),
            .clk_o  (clk_v[k]),
            .tick_o (tick_v[k]),
            .busy_o (busy_v[k])
        );
    end

    assign bus.clk_o  = clk_v;
    assign bus.tick_o = tick_v;
    assign bus.busy_o = busy_v;
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed self-checking bench for clk_div_multi with hand-computed edge counts.
module tb_clk_div_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n;

    always #5 clk = ~clk;

    clk_div_multi_if #(.N_CH(4), .CNT_W(16)) bus ();

    clk_div_multi #(.N_CH(4), .CNT_W(16), .DEF_DIV(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int k, input logic [15:0] v);
        bus.div_i[k*16 +: 16] = v;
    endtask

    task automatic wait_rise(input int k, input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.tick_o[k] && cnt < max);
    endtask

    task automatic wait_lvl(input int k, input logic v, input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (bus.clk_o[k] !== v && cnt < max);
    endtask

    task automatic count_ticks(input int k, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.tick_o[k]) cnt++;
        end
    endtask

    initial begin
        bus.en = '0;
        bus.div_i = '0;
        bus.sync_i = 1'b0;
        #12;
        check("rst_clk", bus.clk_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_tick", bus.tick_o, 0);
        check("rst_d", dut.g_ch[0].u_ch.d_q, 100);
        @(negedge clk);
        rst_n = 1'b1;

        // channel 0, D=100: first rise 100 edges after enable, then period 200
        set_div(0, 100);
        bus.en[0] = 1'b1;
        step();
        check("en_busy", bus.busy_o, 4'b0001);
        check("en_clk_low", bus.clk_o, 0);
        wait_rise(0, 300, n);
        check("first_rise", n, 100);
        check("rise_clk", bus.clk_o[0], 1);
        check("others_idle", {bus.clk_o[3:1], bus.tick_o[3:1]}, 0);
        step();
        check("tick_one_cycle", bus.tick_o[0], 0);
        wait_rise(0, 300, n);
        check("period", n, 199);

        // divisor change mid high phase: current half stays 100, then 10
        repeat (50) step();
        set_div(0, 10);
        wait_lvl(0, 1'b0, 300, n);
        check("old_half", n, 50);
        wait_rise(0, 300, n);
        check("new_low", n, 10);
        wait_lvl(0, 1'b0, 300, n);
        check("new_high", n, 10);
        bus.en[0] = 1'b0;
        step();
        check("stop_low_idle", bus.busy_o[0], 0);

        // channel 1, D=8: drop en 3 edges into high phase
        set_div(1, 8);
        bus.en[1] = 1'b1;
        step();
        wait_rise(1, 50, n);
        check("d8_rise", n, 8);
        step();
        step();
        bus.en[1] = 1'b0;
        step();
        check("drain_busy", bus.busy_o[1], 1);
        check("drain_clk", bus.clk_o[1], 1);
        wait_lvl(1, 1'b0, 50, n);
        check("drain_full_high", n, 5);
        check("drain_busy_fall", bus.busy_o[1], 0);
        count_ticks(1, 20, n);
        check("drain_no_tick", n, 0);

        // channels 2 (D=3) and 3 (D=5): sync coincident with ch2 rising terminal count
        set_div(2, 3);
        set_div(3, 5);
        bus.en[3:2] = 2'b11;
        step();
        repeat (8) step();
        check("pre_sync_clk", bus.clk_o[3:2], 2'b10);
        bus.sync_i = 1'b1;
        step();
        bus.sync_i = 1'b0;
        check("sync_clk", bus.clk_o[3:2], 0);
        check("sync_no_tick", bus.tick_o[3:2], 0);
        check("sync_busy", bus.busy_o[3:2], 2'b11);
        wait_rise(2, 20, n);
        check("sync_rise3", n, 3);
        check("sync_ch3_low", bus.clk_o[3], 0);
        wait_rise(3, 20, n);
        check("sync_rise5", n, 2);
        bus.en[3:2] = 2'b00;
        bus.sync_i = 1'b1;
        step();
        bus.sync_i = 1'b0;
        check("sync_stop", bus.busy_o[3:2], 0);

        // div=0 and div=1 both give clk/2
        set_div(0, 0);
        set_div(1, 1);
        bus.en[1:0] = 2'b11;
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            check("half_clk", bus.clk_o[1:0], (i % 2) ? 2'b11 : 2'b00);
            check("half_tick", bus.tick_o[1:0], (i % 2) ? 2'b11 : 2'b00);
        end
        bus.en[1:0] = 2'b00;
        bus.sync_i = 1'b1;
        step();
        bus.sync_i = 1'b0;
        check("half_stop", bus.busy_o, 0);

        // async reset mid high phase
        set_div(0, 100);
        bus.en[0] = 1'b1;
        step();
        wait_rise(0, 300, n);
        check("pre_rst_rise", n, 100);
        repeat (20) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk", bus.clk_o, 0);
        check("arst_tick", bus.tick_o, 0);
        check("arst_busy", bus.busy_o, 0);
        check("arst_d", dut.g_ch[0].u_ch.d_q, 100);
        bus.en = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", bus.busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider for the game's slow-time domains (scan/keypad sampling, display refresh, buzzer tone, mole timer). Each channel divides the single system clock by a runtime-programmable even ratio, producing a 50 % duty divided clock plus a one-cycle tick strobe on every divided-clock rising edge. Channels start and stop without runt pulses and can be phase-aligned by a common sync. Sits directly below the top level and feeds every slow consumer from one block.

## Interface
- N_CH, 4: number of independent channels.
- CNT_W, 16: width of each channel's half-period counter and divisor.
- DEF_DIV, 100: half-period loaded into every channel's shadow divisor at reset.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  N_CH  per-channel run request, level-sensitive.
- div_i  in  N_CH*CNT_W  per-channel half-period in clk cycles; channel k uses bits [k*CNT_W +: CNT_W].
- sync_i  in  1  one-cycle pulse; restarts every running channel in phase.
- clk_o  out  N_CH  divided clocks, period 2*D clk cycles.
- tick_o  out  N_CH  one-cycle strobe, high in the first cycle clk_o[k] is 1.
- busy_o  out  N_CH  channel state is not IDLE.

## Operation
- Per channel: state (IDLE, RUN, DRAIN), CNT_W counter cnt, shadow divisor D, output register.
- Effective divisor: div_i value 0 is treated as 1; D is never 0.
- IDLE: cnt=0, clk_o=0. On en=1: D<=div_i, cnt<=0, go RUN.
- RUN: cnt increments; when cnt==D-1: cnt<=0, clk_o toggles, D<=div_i (divisor changes take effect only at toggle boundaries, no partial half-periods). If en=0 is sampled: stay counting; if clk_o=0 go IDLE immediately, else go DRAIN.
- DRAIN: keep counting; at cnt==D-1, clk_o falls, go IDLE. en=1 during DRAIN is ignored until IDLE is reached (re-enters RUN on the next cycle if still high).
- tick_o[k] asserted only by a 0->1 toggle of clk_o[k]; never in DRAIN or IDLE.
- sync_i: every channel in RUN or DRAIN gets cnt<=0, clk_o<=0, D<=div_i; a DRAIN channel goes IDLE; a RUN channel with en=0 goes IDLE. sync_i overrides a coincident terminal count (no toggle, no tick). IDLE channels ignore sync_i.
- Channels are fully independent apart from sync_i.

## Timing
- Reset (async assert, sync release on clk): all states IDLE, cnt=0, D=DEF_DIV, clk_o=0, tick_o=0, busy_o=0.
- en sampled high at edge E0 (IDLE): busy_o high after E0; first clk_o rise and tick_o registered at edge E0+D; falls at E0+2D; period 2D, duty exactly D/D.
- D=1: clk_o toggles every cycle (clk/2), tick_o high every other cycle.
- Counter wrap: cnt never exceeds D-1; maximum D=2^CNT_W-1; period 2*(2^CNT_W-1).
- en dropped while high: clk_o completes its current high phase, never shortened; busy_o falls the edge clk_o falls.
- Reset mid-operation: outputs go low asynchronously; a truncated pulse on clk_o is accepted.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package clk_div_pkg: state enum (IDLE, RUN, DRAIN), DEF_DIV default constant.
- Sub-module clk_div_ch: one channel (state, counter, shadow, outputs); clk_div_multi generates N_CH instances and fans out sync_i and slices div_i.

## Test plan
- Reset then en[0]=1, div=100 -> clk_o[0] rises 100 cycles after enable edge, period 200, tick_o[0] one cycle per 200; other channels stay 0.
- div changed 100->10 mid-high-phase -> current half-period stays 100, subsequent half-periods are 10.
- en[1] dropped 3 cycles after clk_o[1] rises (D=8) -> high phase lasts full 8 cycles, busy_o[1] falls with it, no tick afterward.
- Channels with D=3 and D=5 running, sync_i pulse -> both restart; first rises at sync edge+3 and +5, coincident sync and terminal count produces no tick.
- div=0 and div=1 -> both give clk/2 output, tick every second cycle.
- rst_n asserted mid-high-phase -> clk_o, tick_o, busy_o low immediately; after release D=100 restored.
